// File: rtl/ysyx_22040386_csr_ctrl_if.sv
// Handshake and payload bundle between the decode stage and the machine-mode CSR sequencer.
// The decode/pipeline side uses the master modport and the CSR block uses the slave modport.
interface ysyx_22040386_csr_ctrl_if #(
    parameter int XLEN = 64
) ();
    logic            i_CSR_valid;
    logic            o_CSR_ready;
    logic [1:0]      i_CSR_state;
    logic            i_CSR_op_set;
    logic [11:0]     i_CSR_addr;
    logic [XLEN-1:0] i_CSR_wdata;
    logic [XLEN-1:0] i_CSR_pc;
    logic            o_CSR_done;
    logic [XLEN-1:0] o_CSR_rdata;
    logic            o_CSR_redirect;
    logic [XLEN-1:0] o_CSR_redirect_pc;
    logic            o_CSR_illegal;

    modport master (
        output i_CSR_valid, i_CSR_state, i_CSR_op_set, i_CSR_addr, i_CSR_wdata, i_CSR_pc,
        input  o_CSR_ready, o_CSR_done, o_CSR_rdata, o_CSR_redirect, o_CSR_redirect_pc, o_CSR_illegal
    );

    modport slave (
        input  i_CSR_valid, i_CSR_state, i_CSR_op_set, i_CSR_addr, i_CSR_wdata, i_CSR_pc,
        output o_CSR_ready, o_CSR_done, o_CSR_rdata, o_CSR_redirect, o_CSR_redirect_pc, o_CSR_illegal
    );
endinterface

// File: rtl/ysyx_22040386_csr_ctrl.sv
// Machine-mode CSR storage plus a 3-state sequencer for csrrw/csrrs, ecall trap entry and mret.
// state | meaning
// IDLE  | ready; latch payload on valid & ready with a non-zero op
// EXEC  | read old value, commit CSR update at the end of the cycle
// RESP  | done pulse with rdata / redirect / illegal, then back to IDLE
module ysyx_22040386_csr_ctrl #(
    parameter int              XLEN         = 64,
    parameter int unsigned     MCAUSE_ECALL = 11,
    parameter logic [XLEN-1:0] MTVEC_RST    = '0
) (
    input  logic                         i_CSR_clk,
    input  logic                         i_CSR_rst,
    ysyx_22040386_csr_ctrl_if.slave      csr_if
);
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_EXEC = 2'd1, S_RESP = 2'd2} state_e;

    localparam logic [1:0] OP_RW    = 2'b01;
    localparam logic [1:0] OP_ECALL = 2'b10;
    localparam logic [1:0] OP_MRET  = 2'b11;

    localparam logic [XLEN-1:0] MSTATUS_RST = XLEN'(64'h1800);

    state_e state_q, state_d;

    logic [1:0]      op_q;
    logic            set_q;
    logic [11:0]     addr_q;
    logic [XLEN-1:0] wdata_q, pc_q;

    logic [XLEN-1:0] mstatus_q, mstatus_d;
    logic [XLEN-1:0] mie_q, mie_d;
    logic [XLEN-1:0] mtvec_q, mtvec_d;
    logic [XLEN-1:0] mscratch_q, mscratch_d;
    logic [XLEN-1:0] mepc_q, mepc_d;
    logic [XLEN-1:0] mcause_q, mcause_d;
    logic [XLEN-1:0] mcycle_q, mcycle_d;

    logic            ready_q, ready_d;
    logic            done_q, done_d;
    logic [XLEN-1:0] rdata_q, rdata_d;
    logic            redirect_q, redirect_d;
    logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;
    logic            illegal_q, illegal_d;

    logic            accept;
    logic            csr_hit;
    logic [XLEN-1:0] csr_old;
    logic [XLEN-1:0] csr_new;
    logic            csr_we;

    // A no-op request (state 00) is swallowed: it never leaves IDLE.
    assign accept = csr_if.i_CSR_valid & ready_q & (csr_if.i_CSR_state != 2'b00);

    always_ff @(posedge i_CSR_clk or posedge i_CSR_rst) begin
        if (i_CSR_rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept) state_d = S_EXEC;
            S_EXEC:  state_d = S_RESP;
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_CSR_clk or posedge i_CSR_rst) begin
        if (i_CSR_rst) begin
            op_q    <= 2'b00;
            set_q   <= 1'b0;
            addr_q  <= 12'h000;
            wdata_q <= '0;
            pc_q    <= '0;
        end else if (accept) begin
            op_q    <= csr_if.i_CSR_state;
            set_q   <= csr_if.i_CSR_op_set;
            addr_q  <= csr_if.i_CSR_addr;
            wdata_q <= csr_if.i_CSR_wdata;
            pc_q    <= csr_if.i_CSR_pc;
        end
    end

    // mip is implemented but hardwired to zero.
    always_comb begin
        csr_hit = 1'b1;
        csr_old = '0;
        case (addr_q)
            12'h300: csr_old = mstatus_q;
            12'h304: csr_old = mie_q;
            12'h305: csr_old = mtvec_q;
            12'h340: csr_old = mscratch_q;
            12'h341: csr_old = mepc_q;
            12'h342: csr_old = mcause_q;
            12'h344: csr_old = '0;
            12'hB00: csr_old = mcycle_q;
            default: csr_hit = 1'b0;
        endcase
    end

    assign csr_new = set_q ? (csr_old | wdata_q) : wdata_q;
    assign csr_we  = (state_q == S_EXEC) && (op_q == OP_RW) && csr_hit &&
                     !(set_q && (wdata_q == '0));

    always_comb begin
        mstatus_d  = mstatus_q;
        mie_d      = mie_q;
        mtvec_d    = mtvec_q;
        mscratch_d = mscratch_q;
        mepc_d     = mepc_q;
        mcause_d   = mcause_q;
        mcycle_d   = mcycle_q + XLEN'(1);
        if (csr_we) begin
            case (addr_q)
                12'h300: mstatus_d  = csr_new;
                12'h304: mie_d      = csr_new;
                12'h305: mtvec_d    = {csr_new[XLEN-1:2], 2'b00};
                12'h340: mscratch_d = csr_new;
                12'h341: mepc_d     = {csr_new[XLEN-1:2], 2'b00};
                12'h342: mcause_d   = csr_new;
                12'hB00: mcycle_d   = csr_new;
                default: ;
            endcase
        end
        if (state_q == S_EXEC && op_q == OP_ECALL) begin
            mepc_d             = pc_q;
            mcause_d           = XLEN'(MCAUSE_ECALL);
            mstatus_d[7]       = mstatus_q[3];
            mstatus_d[3]       = 1'b0;
            mstatus_d[12:11]   = 2'b11;
        end
        if (state_q == S_EXEC && op_q == OP_MRET) begin
            mstatus_d[3]       = mstatus_q[7];
            mstatus_d[7]       = 1'b1;
            mstatus_d[12:11]   = 2'b00;
        end
    end

    always_ff @(posedge i_CSR_clk or posedge i_CSR_rst) begin
        if (i_CSR_rst) begin
            mstatus_q  <= MSTATUS_RST;
            mie_q      <= '0;
            mtvec_q    <= MTVEC_RST;
            mscratch_q <= '0;
            mepc_q     <= '0;
            mcause_q   <= '0;
            mcycle_q   <= '0;
        end else begin
            mstatus_q  <= mstatus_d;
            mie_q      <= mie_d;
            mtvec_q    <= mtvec_d;
            mscratch_q <= mscratch_d;
            mepc_q     <= mepc_d;
            mcause_q   <= mcause_d;
            mcycle_q   <= mcycle_d;
        end
    end

    // Response is computed in EXEC and registered so it is visible exactly during RESP.
    always_comb begin
        ready_d       = (state_d == S_IDLE);
        done_d        = 1'b0;
        rdata_d       = '0;
        redirect_d    = 1'b0;
        redirect_pc_d = '0;
        illegal_d     = 1'b0;
        if (state_q == S_EXEC) begin
            done_d = 1'b1;
            case (op_q)
                OP_RW: begin
                    rdata_d   = csr_old;
                    illegal_d = !csr_hit;
                end
                OP_ECALL: begin
                    redirect_d    = 1'b1;
                    redirect_pc_d = mtvec_q;
                end
                OP_MRET: begin
                    redirect_d    = 1'b1;
                    redirect_pc_d = mepc_q;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_CSR_clk or posedge i_CSR_rst) begin
        if (i_CSR_rst) begin
            ready_q       <= 1'b1;
            done_q        <= 1'b0;
            rdata_q       <= '0;
            redirect_q    <= 1'b0;
            redirect_pc_q <= '0;
            illegal_q     <= 1'b0;
        end else begin
            ready_q       <= ready_d;
            done_q        <= done_d;
            rdata_q       <= rdata_d;
            redirect_q    <= redirect_d;
            redirect_pc_q <= redirect_pc_d;
            illegal_q     <= illegal_d;
        end
    end

    assign csr_if.o_CSR_ready       = ready_q;
    assign csr_if.o_CSR_done        = done_q;
    assign csr_if.o_CSR_rdata       = rdata_q;
    assign csr_if.o_CSR_redirect    = redirect_q;
    assign csr_if.o_CSR_redirect_pc = redirect_pc_q;
    assign csr_if.o_CSR_illegal     = illegal_q;
endmodule

// File: tb/tb_ysyx_22040386_csr_ctrl.sv
// Scoreboard bench for the CSR sequencer: the driver queues expected responses on acceptance,
// an independent monitor pops and compares them whenever done is presented.
module tb_ysyx_22040386_csr_ctrl;
    localparam int XLEN = 64;

    logic clk = 1'b0;
    logic rst = 1'b1;

    ysyx_22040386_csr_ctrl_if #(.XLEN(XLEN)) bus ();

    ysyx_22040386_csr_ctrl #(
        .XLEN(XLEN), .MCAUSE_ECALL(11), .MTVEC_RST(64'h0)
    ) dut (
        .i_CSR_clk(clk),
        .i_CSR_rst(rst),
        .csr_if   (bus.slave)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        string       name;
        logic [63:0] rdata;
        bit          chk_rd;
        logic        redir;
        logic [63:0] rpc;
        logic        ill;
        int          acc;
    } exp_t;

    exp_t q[$];
    int   checks  = 0;
    int   errors  = 0;
    int   rst_req = 0;
    bit   fin     = 1'b0;

    task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", n, act, exp);
        end
    endtask

    // Monitor / scoreboard
    initial begin
        int   rst_seen;
        exp_t e;
        rst_seen = 0;
        forever begin
            @(negedge clk);
            if (rst_req != rst_seen) begin
                rst_seen = rst_req;
                chk("rst_ready",       64'(bus.o_CSR_ready),    64'd1);
                chk("rst_done",        64'(bus.o_CSR_done),     64'd0);
                chk("rst_rdata",       bus.o_CSR_rdata,         64'd0);
                chk("rst_redirect",    64'(bus.o_CSR_redirect), 64'd0);
                chk("rst_redirect_pc", bus.o_CSR_redirect_pc,   64'd0);
                chk("rst_illegal",     64'(bus.o_CSR_illegal),  64'd0);
            end
            if (!rst) begin
                if (bus.o_CSR_done) begin
                    if (q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL spurious_done actual=1 required=0 at cycle %0d", cyc);
                    end else begin
                        e = q.pop_front();
                        if (e.chk_rd) chk({e.name, "_rdata"}, bus.o_CSR_rdata, e.rdata);
                        chk({e.name, "_redirect"},    64'(bus.o_CSR_redirect), 64'(e.redir));
                        chk({e.name, "_redirect_pc"}, bus.o_CSR_redirect_pc,   e.rpc);
                        chk({e.name, "_illegal"},     64'(bus.o_CSR_illegal),  64'(e.ill));
                        chk({e.name, "_latency"},     64'(cyc),                64'(e.acc + 1));
                    end
                end else begin
                    chk("pulse_outside_done", {62'd0, bus.o_CSR_redirect, bus.o_CSR_illegal}, 64'd0);
                end
            end
            if (fin) begin
                chk("queue_drained", 64'(q.size()), 64'd0);
                $display("CHECKS %0d ERRORS %0d", checks, errors);
                $finish;
            end
        end
    end

    task automatic issue(input string name, input logic [1:0] st, input logic set,
                         input logic [11:0] a, input logic [63:0] wd, input logic [63:0] pc,
                         input logic [63:0] er, input bit chk_rd, input logic redir,
                         input logic [63:0] erpc, input logic ill, input bit push,
                         output int acc);
        int   n;
        exp_t e;
        @(negedge clk);
        bus.i_CSR_state  = st;
        bus.i_CSR_op_set = set;
        bus.i_CSR_addr   = a;
        bus.i_CSR_wdata  = wd;
        bus.i_CSR_pc     = pc;
        bus.i_CSR_valid  = 1'b1;
        n = 0;
        while (!bus.o_CSR_ready) begin
            @(negedge clk);
            n++;
            if (n > 20) begin
                $display("FAIL issue_timeout_%s ready actual=0 required=1", name);
                $fatal(1, "ready never returned");
            end
        end
        acc = cyc + 1;
        @(posedge clk);
        #1;
        bus.i_CSR_valid  = 1'b0;
        bus.i_CSR_op_set = ~set;
        bus.i_CSR_addr   = 12'h305;
        bus.i_CSR_wdata  = {$urandom, $urandom};
        bus.i_CSR_pc     = {$urandom, $urandom};
        if (push) begin
            e.name = name; e.rdata = er; e.chk_rd = chk_rd; e.redir = redir;
            e.rpc = erpc; e.ill = ill; e.acc = acc;
            q.push_back(e);
        end
    endtask

    task automatic rw(input string name, input logic set, input logic [11:0] a,
                      input logic [63:0] wd, input logic [63:0] er, input logic ill);
        int acc;
        issue(name, 2'b01, set, a, wd, 64'hDEAD_BEEF, er, 1'b1, 1'b0, 64'd0, ill, 1'b1, acc);
    endtask

    initial begin
        int acc1, acc2, acc_tmp;
        exp_t e;
        bus.i_CSR_valid  = 1'b0;
        bus.i_CSR_state  = 2'b00;
        bus.i_CSR_op_set = 1'b0;
        bus.i_CSR_addr   = 12'h000;
        bus.i_CSR_wdata  = '0;
        bus.i_CSR_pc     = '0;
        #1 rst_req++;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        rw("mtvec_w",  1'b0, 12'h305, 64'h8000_0003, 64'h0, 1'b0);
        rw("mtvec_r",  1'b1, 12'h305, 64'h0, 64'h8000_0000, 1'b0);

        rw("mstatus_w", 1'b0, 12'h300, 64'h8, 64'h1800, 1'b0);
        issue("ecall", 2'b10, 1'b0, 12'h000, 64'h0, 64'h8000_0010,
              64'h0, 1'b1, 1'b1, 64'h8000_0000, 1'b0, 1'b1, acc_tmp);
        rw("mepc_r",    1'b1, 12'h341, 64'h0, 64'h8000_0010, 1'b0);
        rw("mcause_r",  1'b1, 12'h342, 64'h0, 64'd11, 1'b0);
        rw("mstatus_r1", 1'b1, 12'h300, 64'h0, 64'h1880, 1'b0);

        issue("mret", 2'b11, 1'b0, 12'h000, 64'h0, 64'h0,
              64'h0, 1'b1, 1'b1, 64'h8000_0010, 1'b0, 1'b1, acc_tmp);
        rw("mstatus_r2", 1'b1, 12'h300, 64'h0, 64'h0088, 1'b0);

        rw("mscratch_w",  1'b0, 12'h340, 64'h55, 64'h0, 1'b0);
        rw("mscratch_s0", 1'b1, 12'h340, 64'h0, 64'h55, 1'b0);
        rw("mscratch_s",  1'b1, 12'h340, 64'hA0, 64'h55, 1'b0);
        rw("mscratch_r",  1'b1, 12'h340, 64'h0, 64'hF5, 1'b0);

        rw("illegal_w",   1'b0, 12'h7C0, 64'hDEAD, 64'h0, 1'b1);
        rw("mscratch_r2", 1'b1, 12'h340, 64'h0, 64'hF5, 1'b0);
        issue("nop", 2'b00, 1'b0, 12'h340, 64'h1, 64'h0,
              64'h0, 1'b1, 1'b0, 64'h0, 1'b0, 1'b0, acc_tmp);
        rw("mip_w",  1'b0, 12'h344, 64'hFF, 64'h0, 1'b0);
        rw("mip_r",  1'b1, 12'h344, 64'h0, 64'h0, 1'b0);
        rw("mepc_w", 1'b0, 12'h341, 64'h1237, 64'h8000_0010, 1'b0);
        rw("mepc_r2", 1'b1, 12'h341, 64'h0, 64'h1234, 1'b0);
        rw("mie_w",  1'b0, 12'h304, 64'hAAA, 64'h0, 1'b0);
        rw("mie_r",  1'b1, 12'h304, 64'h0, 64'hAAA, 1'b0);

        // mcycle: write value, then read after a known number of cycles
        issue("mcycle_w", 2'b01, 1'b0, 12'hB00, 64'd100, 64'h0,
              64'h0, 1'b0, 1'b0, 64'h0, 1'b0, 1'b1, acc1);
        issue("mcycle_r", 2'b01, 1'b1, 12'hB00, 64'h0, 64'h0,
              64'h0, 1'b0, 1'b0, 64'h0, 1'b0, 1'b0, acc2);
        e.name = "mcycle_r"; e.rdata = 64'd100 + 64'(acc2 - acc1 - 1); e.chk_rd = 1'b1;
        e.redir = 1'b0; e.rpc = 64'h0; e.ill = 1'b0; e.acc = acc2;
        q.push_back(e);
        issue("mcycle_wmax", 2'b01, 1'b0, 12'hB00, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0,
              64'h0, 1'b0, 1'b0, 64'h0, 1'b0, 1'b1, acc1);
        issue("mcycle_wrap", 2'b01, 1'b1, 12'hB00, 64'h0, 64'h0,
              64'h0, 1'b0, 1'b0, 64'h0, 1'b0, 1'b0, acc2);
        e.name = "mcycle_wrap"; e.rdata = 64'hFFFF_FFFF_FFFF_FFFF + 64'(acc2 - acc1 - 1);
        e.acc = acc2;
        q.push_back(e);

        // Reset while the ecall is in EXEC: no response may ever appear
        issue("ecall_abort", 2'b10, 1'b0, 12'h000, 64'h0, 64'h8000_0040,
              64'h0, 1'b1, 1'b1, 64'h0, 1'b0, 1'b0, acc_tmp);
        rst = 1'b1;
        rst_req++;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        rw("post_rst_mepc",    1'b1, 12'h341, 64'h0, 64'h0, 1'b0);
        rw("post_rst_mstatus", 1'b1, 12'h300, 64'h0, 64'h1800, 1'b0);
        rw("post_rst_mtvec",   1'b1, 12'h305, 64'h0, 64'h0, 1'b0);

        repeat (6) @(posedge clk);
        #1 fin = 1'b1;
        repeat (50) @(posedge clk);
        $display("FAIL monitor_timeout actual=running required=finished");
        $fatal(1, "monitor did not finish");
    end
endmodule
